// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared constants for the board datapath: board geometry, line-clear FSM state
// encoding and the per-run score table.
// No ports (package).
// -----------------------------------------------------------------------------
package tetris_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;
    localparam int BOARD_BITS = BOARD_ROWS * BOARD_COLS;

    localparam logic [1:0] LC_IDLE = 2'd0;
    localparam logic [1:0] LC_SCAN = 2'd1;
    localparam logic [1:0] LC_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = LC_IDLE,
        ST_SCAN = LC_SCAN,
        ST_DONE = LC_DONE
    } lc_state_t;

    localparam logic [11:0] SCORE_1 = 12'd100;
    localparam logic [11:0] SCORE_2 = 12'd300;
    localparam logic [11:0] SCORE_3 = 12'd500;
    localparam logic [11:0] SCORE_4 = 12'd800;

    // Points awarded for one run; four or more lines all score as a tetris.
    function automatic logic [11:0] score_for_lines(input logic [4:0] n);
        logic [11:0] s;
        case (n)
            5'd0:    s = 12'd0;
            5'd1:    s = SCORE_1;
            5'd2:    s = SCORE_2;
            5'd3:    s = SCORE_3;
            default: s = SCORE_4;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lc_row_select.sv
// -----------------------------------------------------------------------------
// lc_row_select
// Combinational row multiplexer for the line-clear engine. Returns the COLS
// bits of row `ptr` and whether that row is completely filled. A pointer at or
// beyond ROWS selects nothing (row reads as zero, not full).
// Ports:
//   board  in  [0:ROWS*COLS-1]  board, row r at bits r*COLS .. r*COLS+COLS-1
//   ptr    in  [PTR_W-1:0]      row index (0 = bottom)
//   row    out [COLS-1:0]       row[c] = board[ptr*COLS + c]
//   full   out 1                all bits of the selected row are set
// -----------------------------------------------------------------------------
module lc_row_select
    import tetris_pkg::*;
#(
    parameter int ROWS  = BOARD_ROWS,
    parameter int COLS  = BOARD_COLS,
    parameter int PTR_W = 5
) (
    input  logic [0:ROWS*COLS-1] board,
    input  logic [PTR_W-1:0]     ptr,
    output logic [COLS-1:0]      row,
    output logic                 full
);

    always_comb begin
        row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (ptr == PTR_W'(r)) begin
                for (int c = 0; c < COLS; c++) begin
                    row[c] = board[r*COLS + c];
                end
            end
        end
    end

    assign full = (ptr < PTR_W'(ROWS)) && (&row);

endmodule

// File: rtl/line_clear_engine.sv
// -----------------------------------------------------------------------------
// line_clear_engine
// Sequential line-clear stage between piece merge and the static board
// register. Removes every full row, one per clock, shifting the rows above
// down and filling zeros from the top. Reports the compacted board, the
// number of lines removed and a one-cycle done pulse.
//
// Optional feature: define LINE_CLEAR_SCORE_EN to register score_delta from
// the line count on entry to DONE. Without it score_delta is tied to zero.
//
// Ports:
//   clk          in  1                 system clock, rising edge
//   rst_n        in  1                 synchronous active-low reset
//   start        in  1                 run request, sampled only in IDLE
//   board_in     in  [0:ROWS*COLS-1]   merged board, row 0 at the bottom
//   busy         out 1                 state is not IDLE
//   done         out 1                 one-cycle pulse, results valid
//   board_out    out [0:ROWS*COLS-1]   working / compacted board
//   lines        out [4:0]             full rows removed in the last run
//   score_delta  out [11:0]            points for the last run
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; results of the previous run held
// SCAN  | ptr 0..ROWS-1: examine row ptr, clear it or advance;
//       | ptr == ROWS: scan exhausted, settle edge before DONE
// DONE  | done asserted for one cycle, then back to IDLE
// -----------------------------------------------------------------------------
module line_clear_engine
    import tetris_pkg::*;
#(
    parameter int ROWS = BOARD_ROWS,
    parameter int COLS = BOARD_COLS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [0:ROWS*COLS-1] board_in,
    output logic                 busy,
    output logic                 done,
    output logic [0:ROWS*COLS-1] board_out,
    output logic [4:0]           lines,
    output logic [11:0]          score_delta
);

    // ptr must be able to reach ROWS, which marks the end-of-scan settle edge.
    localparam int PTR_W = $clog2(ROWS + 1);

    lc_state_t             state_q, state_d;
    logic [0:ROWS*COLS-1]  board_q, board_d, board_shifted;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [4:0]            lines_q, lines_d;
    logic [COLS-1:0]       cur_row;
    logic                  cur_full;
    logic                  scan_end;

    lc_row_select #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .PTR_W (PTR_W)
    ) u_row_select (
        .board (board_q),
        .ptr   (ptr_q),
        .row   (cur_row),
        .full  (cur_full)
    );

    assign scan_end = (ptr_q == PTR_W'(ROWS));

    // Drop row ptr: every row at or above it takes the row above; top row zeroed.
    always_comb begin
        board_shifted = board_q;
        for (int r = 0; r < ROWS; r++) begin
            if (PTR_W'(r) >= ptr_q) begin
                if (r == ROWS - 1) begin
                    board_shifted[r*COLS +: COLS] = '0;
                end else begin
                    board_shifted[r*COLS +: COLS] = board_q[(r+1)*COLS +: COLS];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        ptr_d   = ptr_q;
        lines_d = lines_q;
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    board_d = board_in;
                    ptr_d   = '0;
                    lines_d = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_end) begin
                    state_d = ST_DONE;
                end else if (cur_full) begin
                    board_d = board_shifted;
                    lines_d = lines_q + 5'd1;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            board_q <= '0;
            ptr_q   <= '0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            ptr_q   <= ptr_d;
            lines_q <= lines_d;
        end
    end

    assign board_out = board_q;
    assign lines     = lines_q;

`ifdef LINE_CLEAR_SCORE_EN
    logic [11:0] score_q;

    // Line count is final by the settle edge, so latch the score there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            score_q <= '0;
        end else if (state_q == ST_SCAN && scan_end) begin
            score_q <= score_for_lines(lines_q);
        end
    end

    assign score_delta = score_q;
`else
    assign score_delta = '0;
`endif

    logic unused_row;
    assign unused_row = ^cur_row;

endmodule
